// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command encodings, controller states and rx_data field layout
package spi_ram_pkg;
  localparam int RX_W   = 10;
  localparam int CMD_HI = 9;
  localparam int CMD_LO = 8;
  localparam int PAY_HI = 7;
  localparam int PAY_LO = 0;
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ACCESS = 2'd1,
    TX_RESP   = 2'd2
  } state_e;
endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: DEPTH x 8 storage, one sync write port and one registered read port
module spi_ram_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes SPI command words, sequences memory writes/reads and holds read responses
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 1,
  parameter int TX_HOLD   = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [RX_W-1:0] rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  output logic            busy,
  output logic            cmd_err,
  output logic            overrun
);
  localparam int CW = $clog2(TX_HOLD + 1);
  state_e                 state, state_nx;
  cmd_e                   cmd;
  logic [ADDR_SIZE-1:0]   pay, wr_ptr, rd_ptr;
  logic                   rd_vld, take, pay_ok, we, rd_go, bad;
  logic [CW-1:0]          cnt;
  logic [7:0]             mem_q;
  function automatic logic [ADDR_SIZE-1:0] nxt(input logic [ADDR_SIZE-1:0] p);
    return (AUTO_INC == 0) ? p : (32'(p) == 32'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign cmd    = cmd_e'(rx_data[CMD_HI:CMD_LO]);
  assign pay    = ADDR_SIZE'(rx_data[PAY_HI:PAY_LO]);
  assign pay_ok = 32'(pay) < 32'(MEM_DEPTH);
  assign take   = rx_valid && state == IDLE;
  assign we     = take && cmd == CMD_WR_DATA;
  assign rd_go  = take && cmd == CMD_RD_DATA && rd_vld;
  assign bad    = (cmd == CMD_RD_DATA && !rd_vld) ||
                  ((cmd == CMD_WR_ADDR || cmd == CMD_RD_ADDR) && !pay_ok);
  assign busy   = state != IDLE;
  // read port tracks rd_ptr continuously, so data is ready in RD_ACCESS
  spi_ram_mem #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (rx_data[PAY_HI:PAY_LO]),
    .raddr (rd_ptr),
    .rdata (mem_q)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = rd_go ? RD_ACCESS : IDLE;
      RD_ACCESS: state_nx = TX_RESP;
      TX_RESP:   state_nx = (cnt == '0) ? IDLE : TX_RESP;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cmd_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      cmd_err <= take && bad;
      overrun <= rx_valid && state != IDLE;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_vld <= 1'b0;
    end else begin
      if (take && cmd == CMD_WR_ADDR && pay_ok) wr_ptr <= pay;
      if (we) wr_ptr <= nxt(wr_ptr);
      if (take && cmd == CMD_RD_ADDR && pay_ok) begin
        rd_ptr <= pay;
        rd_vld <= 1'b1;
      end
      if (state == RD_ACCESS) rd_ptr <= nxt(rd_ptr);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      cnt      <= '0;
    end else if (state == RD_ACCESS) begin
      tx_data  <= mem_q;
      tx_valid <= 1'b1;
      cnt      <= CW'(TX_HOLD - 1);
    end else if (state == TX_RESP) begin
      cnt      <= (cnt == '0) ? cnt : cnt - 1'b1;
      tx_valid <= cnt != '0;
    end
  end
endmodule
